usb_key_sequencer: RTL and testbench
====================================

USB_KEY_SEQUENCER -- requirements
Module: usb_key_sequencer

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, character FIFO entries (power of 2); REP_DELAY, default 24'd12000000, cycles before first repeat; REP_RATE, default 24'd1200000, cycles between repeats.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rep_valid  in  1  HID boot report presented
- rep_ready  out  1  report accepted when rep_valid & rep_ready
- rep_mod  in  8  modifier byte (bit0 LCtrl ... bit7 RGUI)
- rep_keys  in  48  six keycode slots; slot i = bits [8i+7:8i]
- conv_r0  out  8  modifier byte to converter
- conv_r2  out  8  keycode to converter
- conv_result  in  8  converter ASCII, registered, valid one clk after conv_r2 is driven
- char_valid  out  1  FIFO non-empty
- char_data  out  8  FIFO head character
- char_ready  in  1  consumer pops head when char_valid & char_ready
- overflow  out  1  sticky; character dropped on full FIFO

Function
REQ-003 SHALL be a sequencer with states IDLE, SCAN, APPLY, CAPTURE, RELEASE.
REQ-004 rep_ready SHALL be 1 only in IDLE, when no repeat is pending.
REQ-005 On acceptance, SHALL register rep_mod and rep_keys, then enter SCAN with slot index 0.
REQ-006 If any accepted slot equals 8'h01 (rollover error), SHALL discard the report: keep stored previous-report keys, stay in IDLE, leave repeat state unchanged.
REQ-007 SCAN SHALL examine one slot per cycle, in order 0..5. A slot is new when nonzero and not equal to any of the six previous-report slots. A new slot SHALL go to APPLY. Otherwise the index SHALL advance. After slot 5, previous-report keys SHALL be replaced by the accepted keys, and the FSM SHALL return to IDLE.
REQ-008 APPLY (1 cycle) SHALL drive conv_r0 = registered modifier and conv_r2 = keycode, then go to CAPTURE.
REQ-009 CAPTURE (1 cycle) SHALL hold conv_r0/conv_r2 and sample conv_result.
- Push the sample unless the keycode is 8'h39, 8'h47 or 8'h53 (lock keys) or the sample is 8'h00.
- Then go to RELEASE.
REQ-010 RELEASE (1 cycle) SHALL drive conv_r2 = 8'h00, so the same keycode applied again is seen as a change. It SHALL then resume SCAN at the next slot, or return to IDLE for a repeat.
REQ-011 In IDLE, conv_r2 SHALL be 8'h00 and conv_r0 SHALL hold the last accepted modifier.
REQ-012 Latency from report acceptance to first character in FIFO SHALL be (slot index + 1) SCAN cycles + 2 cycles (APPLY, CAPTURE).
REQ-013 A pushed non-lock key SHALL become the repeat key, and the repeat counter SHALL load REP_DELAY.
REQ-014 The repeat counter SHALL decrement every cycle while nonzero and a repeat key exists.
REQ-015 On reaching zero in IDLE, the repeat key SHALL be re-sequenced (APPLY, CAPTURE, RELEASE) with the current modifier, and the counter SHALL reload REP_RATE.
REQ-016 A repeat due while a report is being processed SHALL wait until IDLE; at most one repeat SHALL be pending.
REQ-017 An accepted, non-discarded report without the repeat key SHALL clear the repeat key.
REQ-018 FIFO SHALL be FIFO_DEPTH deep, first-in first-out, with pointers wrapping modulo FIFO_DEPTH.
REQ-019 Simultaneous push and pop on a full FIFO SHALL succeed with occupancy unchanged.
REQ-020 Push on full without pop SHALL drop the character and set overflow; overflow SHALL clear only on reset.
REQ-021 Pop on empty SHALL be ignored.
REQ-022 char_data SHALL be stable while char_valid & !char_ready.

Reset
REQ-023 rst_n low SHALL immediately force:
- state IDLE, slot index 0
- conv_r0 = 8'h00, conv_r2 = 8'h00
- previous-report keys all 8'h00
- repeat key cleared, counter 0
- FIFO empty, char_valid = 0, overflow = 0, rep_ready = 0 while reset is asserted
REQ-024 Reset asserted mid-sequence SHALL abandon the sequence with no partial push. After release, rep_ready SHALL be 1 on the first clk edge.

Verification
REQ-025 Report mod=00, keys={04,00,00,00,00,00}, converter model returns 8'h61 -> conv_r2=04 for 2 cycles then 00; char_data=8'h61 within 3 cycles of acceptance.
REQ-026 Report keys={04,05,...} followed by keys={05,04,...} -> exactly two characters total; the second report pushes nothing.
REQ-027 Report containing 8'h39 -> conv_r2=39 applied, no FIFO push; keys={01,01,01,01,01,01} -> report discarded, no conv_r2 activity.
REQ-028 Hold keys={04,...} with REP_DELAY=10, REP_RATE=4 -> character pushes at cycles 0, ~10 and ~14 after the first push; next report keys={00,...} -> repeat stops.
REQ-029 FIFO_DEPTH=4, char_ready=0, five new keys -> four stored, overflow=1. Popping then yields the first four in order.
REQ-030 rst_n pulsed low during CAPTURE -> all outputs at reset values, FIFO empty, no character later emitted for that report.

Source files
------------

// File: rtl/usb_key_sequencer.sv
// USB boot-keyboard report sequencer.
// Finds keys that are newly pressed in each accepted report, runs them one at a time
// through an external keycode-to-ASCII converter, and queues the characters in a small FIFO.
// The most recent printable key auto-repeats: a long first delay, then a faster rate.
module usb_key_sequencer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [23:0] REP_DELAY  = 24'd12000000,
  parameter logic [23:0] REP_RATE   = 24'd1200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rep_valid,
  output logic        rep_ready,
  input  logic [7:0]  rep_mod,
  input  logic [47:0] rep_keys,
  output logic [7:0]  conv_r0,
  output logic [7:0]  conv_r2,
  input  logic [7:0]  conv_result,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        overflow
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SCAN, APPLY, CAPTURE, RELEASE} state_t;

  state_t          state, state_next;
  logic [2:0]      slot_idx;
  logic [7:0]      mod_reg, cur_key, rep_key, cur_slot;
  logic [5:0][7:0] in_keys, keys_reg, prev_keys;
  logic            ready_en, repeating, rep_active;
  logic [23:0]     rep_cnt;
  logic            rollover, key_held, slot_new, is_lock, rep_due, accept;
  logic            accept_ok, start_rep, load_key, advance, finish, push_req;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, do_pop, do_write;

  assign in_keys    = rep_keys;
  assign cur_slot   = keys_reg[slot_idx];
  assign rep_due    = rep_active && (rep_cnt == 24'd0);
  assign rep_ready  = ready_en && (state == IDLE) && !rep_due;
  assign accept     = rep_valid && rep_ready;
  assign is_lock    = (cur_key == 8'h39) || (cur_key == 8'h47) || (cur_key == 8'h53);
  assign conv_r0    = mod_reg;
  assign conv_r2    = ((state == APPLY) || (state == CAPTURE)) ? cur_key : 8'h00;
  assign full       = (count == CNT_FULL);
  assign char_valid = (count != '0);
  assign char_data  = fifo_mem[rd_ptr];
  assign do_pop     = char_valid && char_ready;
  assign do_write   = push_req && (!full || do_pop);

  // Compare incoming and stored key sets: rollover marker, repeat key still held, slot novelty
  always_comb begin
    rollover = 1'b0;
    key_held = 1'b0;
    slot_new = (cur_slot != 8'h00);
    for (int i = 0; i < 6; i++) begin
      if (in_keys[i] == 8'h01) rollover = 1'b1;
      if (in_keys[i] == rep_key) key_held = 1'b1;
      if (prev_keys[i] == cur_slot) slot_new = 1'b0;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-state control strobes
  always_comb begin
    state_next = state;
    accept_ok  = 1'b0;
    start_rep  = 1'b0;
    load_key   = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        if (rep_due) begin
          start_rep  = 1'b1;
          state_next = APPLY;
        end else if (accept && !rollover) begin
          accept_ok  = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (slot_new) begin
          load_key   = 1'b1;
          state_next = APPLY;
        end else if (slot_idx == 3'd5) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          advance    = 1'b1;
        end
      end
      APPLY: state_next = CAPTURE;
      CAPTURE: begin
        push_req   = !is_lock && (conv_result != 8'h00);
        state_next = RELEASE;
      end
      RELEASE: begin
        if (repeating) begin
          state_next = IDLE;
        end else if (slot_idx == 3'd5) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else begin
          advance    = 1'b1;
          state_next = SCAN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Report registers, slot index and the key currently being converted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      slot_idx  <= 3'd0;
      mod_reg   <= 8'h00;
      keys_reg  <= '0;
      prev_keys <= '0;
      cur_key   <= 8'h00;
      repeating <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept_ok) begin
        mod_reg   <= rep_mod;
        keys_reg  <= rep_keys;
        slot_idx  <= 3'd0;
        repeating <= 1'b0;
      end
      if (start_rep) begin
        cur_key   <= rep_key;
        repeating <= 1'b1;
      end
      if (load_key) cur_key <= cur_slot;
      if (advance)  slot_idx <= slot_idx + 3'd1;
      if (finish) begin
        prev_keys <= keys_reg;
        slot_idx  <= 3'd0;
      end
    end
  end

  // Auto-repeat: remember the last printable key and count down to its next replay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_key    <= 8'h00;
      rep_active <= 1'b0;
      rep_cnt    <= 24'd0;
    end else if (accept_ok && rep_active && !key_held) begin
      rep_key    <= 8'h00;
      rep_active <= 1'b0;
      rep_cnt    <= 24'd0;
    end else if (push_req && !repeating) begin
      rep_key    <= cur_key;
      rep_active <= 1'b1;
      rep_cnt    <= REP_DELAY;
    end else if (start_rep) begin
      rep_cnt <= REP_RATE;
    end else if (rep_active && (rep_cnt != 24'd0)) begin
      rep_cnt <= rep_cnt - 24'd1;
    end
  end

  // Character FIFO storage; a push into a full FIFO is accepted only alongside a pop
  always_ff @(posedge clk) begin
    if (do_write) fifo_mem[wr_ptr] <= conv_result;
  end

  // Character FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (do_write && !do_pop)      count <= count + 1'b1;
      else if (!do_write && do_pop) count <= count - 1'b1;
      if (push_req && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_key_sequencer.sv
// Directed bench for usb_key_sequencer: one instance with default repeat timing for the
// sequencing/FIFO scenarios, a second with short repeat timing for the auto-repeat scenario.
module tb_usb_key_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rep_valid, r_valid;
  logic [7:0]  rep_mod;
  logic [47:0] rep_keys;
  logic        char_ready, r_char_ready;

  logic        rep_ready, char_valid, overflow;
  logic [7:0]  conv_r0, conv_r2, conv_result, char_data;
  logic        r_rep_ready, r_char_valid, r_overflow;
  logic [7:0]  r_conv_r0, r_conv_r2, r_conv_result, r_char_data;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  got [16];
  int          got_n;

  always #5 clk = ~clk;

  usb_key_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .rep_valid(rep_valid), .rep_ready(rep_ready),
    .rep_mod(rep_mod), .rep_keys(rep_keys), .conv_r0(conv_r0), .conv_r2(conv_r2),
    .conv_result(conv_result), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .overflow(overflow)
  );

  usb_key_sequencer #(.FIFO_DEPTH(4), .REP_DELAY(24'd10), .REP_RATE(24'd4)) u_rep (
    .clk(clk), .rst_n(rst_n), .rep_valid(r_valid), .rep_ready(r_rep_ready),
    .rep_mod(rep_mod), .rep_keys(rep_keys), .conv_r0(r_conv_r0), .conv_r2(r_conv_r2),
    .conv_result(r_conv_result), .char_valid(r_char_valid), .char_data(r_char_data),
    .char_ready(r_char_ready), .overflow(r_overflow)
  );

  // Converter model: registered, keycode + 0x5D (0x04 -> 'a'), zero stays zero
  always @(posedge clk) begin
    conv_result   <= (conv_r2 == 8'h00) ? 8'h00 : conv_r2 + 8'h5D;
    r_conv_result <= (r_conv_r2 == 8'h00) ? 8'h00 : r_conv_r2 + 8'h5D;
  end

  function automatic logic [47:0] mk(input logic [7:0] k0, k1, k2, k3, k4, k5);
    return {k5, k4, k3, k2, k1, k0};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a report to one instance; returns one tick after the accepting edge
  task automatic send(input bit inst, input logic [7:0] m, input logic [47:0] k);
    int w = 0;
    rep_mod  = m;
    rep_keys = k;
    if (inst) r_valid = 1'b1;
    else      rep_valid = 1'b1;
    while (!(inst ? r_rep_ready : rep_ready) && w < 200) begin
      step(1);
      w++;
    end
    vectors++;
    if (!(inst ? r_rep_ready : rep_ready)) begin
      miscompares++;
      $display("[TB] FAIL send_handshake: rep_ready=0, required 1 within 200 cycles");
    end
    step(1);
    rep_valid = 1'b0;
    r_valid   = 1'b0;
  endtask

  task automatic wait_idle(input bit inst);
    int w = 0;
    while (!(inst ? r_rep_ready : rep_ready) && w < 200) begin
      step(1);
      w++;
    end
    vectors++;
    if (!(inst ? r_rep_ready : rep_ready)) begin
      miscompares++;
      $display("[TB] FAIL wait_idle: rep_ready=0, required 1 within 200 cycles");
    end
  endtask

  task automatic drain();
    got_n = 0;
    char_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (char_valid && got_n < 16) begin
        got[got_n] = char_data;
        got_n++;
      end
      step(1);
    end
    char_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    vectors += 5;
    if (rep_ready !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_rep_ready: got %b, expected 0", rep_ready); end
    if (char_valid !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_char_valid: got %b, expected 0", char_valid); end
    if (overflow !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_overflow: got %b, expected 0", overflow); end
    if (conv_r0 !== 8'h00)    begin miscompares++; $display("[TB] FAIL reset_conv_r0: got %h, expected 00", conv_r0); end
    if (conv_r2 !== 8'h00)    begin miscompares++; $display("[TB] FAIL reset_conv_r2: got %h, expected 00", conv_r2); end
    rst_n = 1'b1;
    step(1);
    vectors += 2;
    if (rep_ready !== 1'b1)   begin miscompares++; $display("[TB] FAIL reset_release_ready: got %b, expected 1", rep_ready); end
    if (r_rep_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_release_r_ready: got %b, expected 1", r_rep_ready); end
  endtask

  task automatic test_single();
    send(0, 8'h00, mk(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    vectors++;
    if (conv_r2 !== 8'h00) begin miscompares++; $display("[TB] FAIL single_scan_r2: got %h, expected 00", conv_r2); end
    step(1);
    vectors++;
    if (conv_r2 !== 8'h04) begin miscompares++; $display("[TB] FAIL single_apply_r2: got %h, expected 04", conv_r2); end
    step(1);
    vectors += 2;
    if (conv_r2 !== 8'h04)   begin miscompares++; $display("[TB] FAIL single_capture_r2: got %h, expected 04", conv_r2); end
    if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early_char: got %b, expected 0", char_valid); end
    step(1);
    vectors += 3;
    if (conv_r2 !== 8'h00)   begin miscompares++; $display("[TB] FAIL single_release_r2: got %h, expected 00", conv_r2); end
    if (char_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_char_valid: got %b, expected 1", char_valid); end
    if (char_data !== 8'h61) begin miscompares++; $display("[TB] FAIL single_char_data: got %h, expected 61", char_data); end
    wait_idle(0);
    drain();
    vectors += 2;
    if (got_n !== 1)         begin miscompares++; $display("[TB] FAIL single_count: got %0d, expected 1", got_n); end
    if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_empty: got %b, expected 0", char_valid); end
  endtask

  task automatic test_modifier();
    send(0, 8'h00, '0);
    wait_idle(0);
    send(0, 8'h02, mk(8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00));
    step(2);
    vectors++;
    if (conv_r2 !== 8'h00) begin miscompares++; $display("[TB] FAIL mod_scan_r2: got %h, expected 00", conv_r2); end
    step(1);
    vectors += 2;
    if (conv_r2 !== 8'h07) begin miscompares++; $display("[TB] FAIL mod_apply_r2: got %h, expected 07", conv_r2); end
    if (conv_r0 !== 8'h02) begin miscompares++; $display("[TB] FAIL mod_apply_r0: got %h, expected 02", conv_r0); end
    step(1);
    vectors++;
    if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mod_early_char: got %b, expected 0", char_valid); end
    step(1);
    vectors += 2;
    if (char_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mod_char_valid: got %b, expected 1", char_valid); end
    if (char_data !== 8'h64) begin miscompares++; $display("[TB] FAIL mod_char_data: got %h, expected 64", char_data); end
    wait_idle(0);
    vectors += 2;
    if (conv_r0 !== 8'h02) begin miscompares++; $display("[TB] FAIL mod_idle_r0: got %h, expected 02", conv_r0); end
    if (conv_r2 !== 8'h00) begin miscompares++; $display("[TB] FAIL mod_idle_r2: got %h, expected 00", conv_r2); end
    drain();
  endtask

  task automatic test_no_change();
    send(0, 8'h00, '0);
    wait_idle(0);
    send(0, 8'h00, mk(8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00));
    wait_idle(0);
    send(0, 8'h00, mk(8'h05, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00));
    wait_idle(0);
    drain();
    vectors++;
    if (got_n !== 2) begin
      miscompares++;
      $display("[TB] FAIL nochange_count: got %0d, expected 2", got_n);
    end else begin
      vectors += 2;
      if (got[0] !== 8'h61) begin miscompares++; $display("[TB] FAIL nochange_first: got %h, expected 61", got[0]); end
      if (got[1] !== 8'h62) begin miscompares++; $display("[TB] FAIL nochange_second: got %h, expected 62", got[1]); end
    end
  endtask

  task automatic test_lock();
    bit busy, saw39;
    send(0, 8'h00, '0);
    wait_idle(0);
    send(0, 8'h00, mk(8'h39, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    step(1);
    vectors++;
    if (conv_r2 !== 8'h39) begin miscompares++; $display("[TB] FAIL lock_apply_r2: got %h, expected 39", conv_r2); end
    wait_idle(0);
    step(2);
    vectors++;
    if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lock_no_push: got %b, expected 0", char_valid); end
    send(0, 8'h00, mk(8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01));
    vectors++;
    if (rep_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rollover_stay_idle: got %b, expected 1", rep_ready); end
    busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (conv_r2 !== 8'h00) busy = 1'b1;
      step(1);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rollover_r2_activity: got %b, expected 0", busy); end
    send(0, 8'h00, mk(8'h39, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00));
    saw39 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (conv_r2 === 8'h39) saw39 = 1'b1;
      step(1);
    end
    vectors++;
    if (saw39 !== 1'b0) begin miscompares++; $display("[TB] FAIL rollover_prev_kept: got %b, expected 0", saw39); end
    drain();
    vectors++;
    if (got_n !== 1) begin
      miscompares++;
      $display("[TB] FAIL lock_after_count: got %0d, expected 1", got_n);
    end else begin
      vectors++;
      if (got[0] !== 8'h61) begin miscompares++; $display("[TB] FAIL lock_after_data: got %h, expected 61", got[0]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_c;
    send(0, 8'h00, '0);
    wait_idle(0);
    char_ready = 1'b0;
    send(0, 8'h00, mk(8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00));
    wait_idle(0);
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag: got %b, expected 1", overflow); end
    drain();
    vectors++;
    if (got_n !== 4) begin
      miscompares++;
      $display("[TB] FAIL ovf_count: got %0d, expected 4", got_n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_c = 8'h61 + 8'(i);
        vectors++;
        if (got[i] !== exp_c) begin miscompares++; $display("[TB] FAIL ovf_order[%0d]: got %h, expected %h", i, got[i], exp_c); end
      end
    end
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky: got %b, expected 1", overflow); end
  endtask

  task automatic test_mid_reset();
    bit leaked;
    send(0, 8'h00, '0);
    wait_idle(0);
    send(0, 8'h00, mk(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    step(2);
    vectors++;
    if (conv_r2 !== 8'h04) begin miscompares++; $display("[TB] FAIL midrst_capture_r2: got %h, expected 04", conv_r2); end
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (conv_r2 !== 8'h00)   begin miscompares++; $display("[TB] FAIL midrst_r2: got %h, expected 00", conv_r2); end
    if (char_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_char_valid: got %b, expected 0", char_valid); end
    if (overflow !== 1'b0)   begin miscompares++; $display("[TB] FAIL midrst_overflow: got %b, expected 0", overflow); end
    if (rep_ready !== 1'b0)  begin miscompares++; $display("[TB] FAIL midrst_rep_ready: got %b, expected 0", rep_ready); end
    step(2);
    rst_n = 1'b1;
    step(1);
    vectors++;
    if (rep_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_release_ready: got %b, expected 1", rep_ready); end
    leaked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (char_valid !== 1'b0) leaked = 1'b1;
      step(1);
    end
    vectors++;
    if (leaked !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_no_char: got %b, expected 0", leaked); end
  endtask

  task automatic test_repeat();
    int pt [16];
    int n, gap;
    logic [7:0] first_c;
    n = 0;
    first_c = 8'h00;
    send(1, 8'h00, mk(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
    for (int i = 0; i < 40; i++) begin
      if (r_char_valid && n < 16) begin
        if (n == 0) first_c = r_char_data;
        pt[n] = i;
        n++;
      end
      step(1);
    end
    vectors++;
    if (n < 3) begin
      miscompares++;
      $display("[TB] FAIL rep_push_count: got %0d, expected at least 3", n);
    end else begin
      vectors += 4;
      if (pt[0] !== 3)       begin miscompares++; $display("[TB] FAIL rep_first_latency: got %0d, expected 3", pt[0]); end
      if (first_c !== 8'h61) begin miscompares++; $display("[TB] FAIL rep_first_data: got %h, expected 61", first_c); end
      gap = pt[1] - pt[0];
      if (gap < 10 || gap > 14) begin miscompares++; $display("[TB] FAIL rep_delay_gap: got %0d, expected 10..14", gap); end
      gap = pt[2] - pt[1];
      if (gap < 4 || gap > 6)   begin miscompares++; $display("[TB] FAIL rep_rate_gap: got %0d, expected 4..6", gap); end
    end
    send(1, 8'h00, '0);
    wait_idle(1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (r_char_valid) n++;
      step(1);
    end
    vectors += 3;
    if (n !== 0)            begin miscompares++; $display("[TB] FAIL rep_stopped: got %0d pushes, expected 0", n); end
    if (r_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL rep_overflow: got %b, expected 0", r_overflow); end
    if (r_conv_r0 !== 8'h00) begin miscompares++; $display("[TB] FAIL rep_conv_r0: got %h, expected 00", r_conv_r0); end
  endtask

  initial begin
    rst_n        = 1'b0;
    rep_valid    = 1'b0;
    r_valid      = 1'b0;
    rep_mod      = 8'h00;
    rep_keys     = '0;
    char_ready   = 1'b0;
    r_char_ready = 1'b1;
    test_reset();
    test_single();
    test_modifier();
    test_no_change();
    test_lock();
    test_overflow();
    test_mid_reset();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
